lt24_frame_writer: RTL and testbench

LT24_FRAME_WRITER -- requirements
Module: lt24_frame_writer

---
 rtl/lt24_pkg.sv | 55 +++++
 rtl/lt24_bus_word.sv | 49 ++++
 rtl/lt24_frame_writer.sv | 219 +++++++++++++++++++++
 tb/tb_lt24_frame_writer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt24_pkg.sv
// Shared types and constants for the LT24 frame writer: FSM states, 8080 bus
// word payload, ILI9341 window/write command codes and panel geometry.
package lt24_pkg;

  localparam int unsigned LCD_W     = 320;
  localparam int unsigned LCD_H     = 240;
  localparam int unsigned COORD_W   = 9;
  localparam int unsigned PIX_W     = 16;
  localparam int unsigned CMD_WORDS = 11;
  localparam int unsigned WIDX_W    = 4;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    FETCH_A,
    FETCH_B,
    WRITE,
    DONE
  } state_t;

  typedef struct packed {
    logic             rs;
    logic [PIX_W-1:0] data;
  } bus_word_t;

  // Word idx of the column/page window setup followed by memory write command.
  function automatic bus_word_t cmd_word(input logic [WIDX_W-1:0]  idx,
                                         input logic [COORD_W-1:0] x0,
                                         input logic [COORD_W-1:0] x1,
                                         input logic [COORD_W-1:0] y0,
                                         input logic [COORD_W-1:0] y1);
    bus_word_t w;
    w.rs   = 1'b1;
    w.data = '0;
    case (idx)
      4'd0:    begin w.rs = 1'b0; w.data = {8'h00, CMD_CASET}; end
      4'd1:    w.data = {15'h0000, x0[8]};
      4'd2:    w.data = {8'h00, x0[7:0]};
      4'd3:    w.data = {15'h0000, x1[8]};
      4'd4:    w.data = {8'h00, x1[7:0]};
      4'd5:    begin w.rs = 1'b0; w.data = {8'h00, CMD_PASET}; end
      4'd6:    w.data = {15'h0000, y0[8]};
      4'd7:    w.data = {8'h00, y0[7:0]};
      4'd8:    w.data = {15'h0000, y1[8]};
      4'd9:    w.data = {8'h00, y1[7:0]};
      default: begin w.rs = 1'b0; w.data = {8'h00, CMD_RAMWR}; end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lt24_bus_word.sv
// Single 8080 write cycle: on go, latch rs/data and drive wr low then high;
// word_done marks the last high cycle so the next go can follow back-to-back.
module lt24_bus_word
  import lt24_pkg::*;
#(
  parameter int unsigned WR_LOW_CYC  = 2,
  parameter int unsigned WR_HIGH_CYC = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic             rs,
  input  logic [PIX_W-1:0] data,
  output logic             word_done,
  output logic             lcd_wr,
  output logic             lcd_rs,
  output logic [PIX_W-1:0] lcd_data
);

  localparam int unsigned LAST  = WR_LOW_CYC + WR_HIGH_CYC - 1;
  localparam int unsigned CNT_W = $clog2(LAST + 1);

  logic             active;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 1'b0;
      cnt      <= '0;
      lcd_wr   <= 1'b1;
      lcd_rs   <= 1'b1;
      lcd_data <= '0;
    end else if (go) begin
      active   <= 1'b1;
      cnt      <= '0;
      lcd_wr   <= 1'b0;
      lcd_rs   <= rs;
      lcd_data <= data;
    end else if (active) begin
      if (cnt == CNT_W'(LAST)) active <= 1'b0;
      else                      cnt    <= cnt + CNT_W'(1);
      // Release wr after the low phase; data only moves on the next go.
      if (cnt == CNT_W'(WR_LOW_CYC - 1)) lcd_wr <= 1'b1;
    end
  end

  assign word_done = active && (cnt == CNT_W'(LAST));

endmodule

// File: rtl/lt24_frame_writer.sv
// LT24 window writer: sends CASET/PASET/RAMWR, then streams one composited
// pixel per fetch/write period. Macro LT24_FRAME_WRITER_TRANSPARENCY_EN enables colour-key transparency.
module lt24_frame_writer
  import lt24_pkg::*;
#(
  parameter int unsigned      NUM_LAYERS  = 3,
  parameter int unsigned      ADDR_W      = 13,
  parameter int unsigned      WR_LOW_CYC  = 2,
  parameter int unsigned      WR_HIGH_CYC = 1,
  parameter logic [PIX_W-1:0] TRANSP_KEY  = 16'hF81F
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [COORD_W-1:0]           x0,
  input  logic [COORD_W-1:0]           x1,
  input  logic [COORD_W-1:0]           y0,
  input  logic [COORD_W-1:0]           y1,
  input  logic [NUM_LAYERS-1:0]        layer_en,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [NUM_LAYERS*ADDR_W-1:0] mem_address,
  output logic                         mem_chipselect,
  output logic                         mem_clken,
  input  logic [NUM_LAYERS*PIX_W-1:0]  mem_readdata,
  output logic                         lcd_cs,
  output logic                         lcd_rs,
  output logic                         lcd_rd,
  output logic                         lcd_wr,
  output logic [PIX_W-1:0]             lcd_data
);

`ifdef LT24_FRAME_WRITER_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  state_t                  state, state_next;
  logic [COORD_W-1:0]      x0_q, x1_q, y0_q, y1_q, w_q, h_q, cx, cy;
  logic [NUM_LAYERS-1:0]   en_q;
  logic [WIDX_W-1:0]       widx;
  logic [ADDR_W-1:0]       p;
  logic                    last_q;
  logic                    valid_c, word_done, go_c, have_base;
  bus_word_t               bw_c;
  logic [PIX_W-1:0]        pix_c;
  logic                    busy_d, done_d, err_d, cs_d, mcs_d;
  logic [NUM_LAYERS*ADDR_W-1:0] addr_d;

  assign valid_c = (x0 <= x1) && (y0 <= y1) &&
                   (x1 <= COORD_W'(LCD_W - 1)) && (y1 <= COORD_W'(LCD_H - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && valid_c) state_next = CMD;
      CMD:     if (word_done && (widx == WIDX_W'(CMD_WORDS - 1))) state_next = FETCH_A;
      FETCH_A: state_next = FETCH_B;
      FETCH_B: state_next = WRITE;
      WRITE:   if (word_done) state_next = last_q ? DONE : FETCH_A;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs follow the state being entered; bus launches follow the current state.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    cs_d   = 1'b1;
    mcs_d  = 1'b0;
    addr_d = '0;
    go_c   = 1'b0;
    bw_c.rs   = 1'b1;
    bw_c.data = '0;
    case (state_next)
      CMD, FETCH_A, FETCH_B, WRITE: begin busy_d = 1'b1; cs_d = 1'b0; end
      DONE:                         done_d = 1'b1;
      default:                      ;
    endcase
    if (state_next == FETCH_A) begin
      mcs_d  = 1'b1;
      addr_d = {NUM_LAYERS{p}};
    end
    case (state)
      IDLE: begin
        if (start && valid_c) begin
          go_c = 1'b1;
          bw_c = cmd_word(WIDX_W'(0), x0, x1, y0, y1);
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      CMD: begin
        if (word_done && (widx != WIDX_W'(CMD_WORDS - 1))) begin
          go_c = 1'b1;
          bw_c = cmd_word(widx + WIDX_W'(1), x0_q, x1_q, y0_q, y1_q);
        end
      end
      FETCH_B: begin
        go_c      = 1'b1;
        bw_c.rs   = 1'b1;
        bw_c.data = pix_c;
      end
      default: ;
    endcase
  end

  // Lowest enabled layer is the base; higher non-key layers paint over it.
  always_comb begin
    pix_c     = '0;
    have_base = 1'b0;
    for (int l = 0; l < int'(NUM_LAYERS); l++) begin
      if (en_q[l]) begin
        if (!TRANSP_EN || !have_base || (mem_readdata[l*PIX_W +: PIX_W] != TRANSP_KEY))
          pix_c = mem_readdata[l*PIX_W +: PIX_W];
        have_base = 1'b1;
      end
    end
  end

  // Window bounds, command index and pixel walk counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q   <= '0;
      x1_q   <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      en_q   <= '0;
      widx   <= '0;
      p      <= '0;
      cx     <= '0;
      cy     <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && valid_c) begin
            x0_q   <= x0;
            x1_q   <= x1;
            y0_q   <= y0;
            y1_q   <= y1;
            w_q    <= x1 - x0;
            h_q    <= y1 - y0;
            en_q   <= layer_en;
            widx   <= '0;
            p      <= '0;
            cx     <= '0;
            cy     <= '0;
            last_q <= 1'b0;
          end
        end
        CMD: begin
          if (word_done && (widx != WIDX_W'(CMD_WORDS - 1))) widx <= widx + WIDX_W'(1);
        end
        FETCH_A: begin
          // Address wraps naturally at ADDR_W bits.
          p      <= p + ADDR_W'(1);
          last_q <= (cx == w_q) && (cy == h_q);
          if (cx == w_q) begin
            cx <= '0;
            cy <= cy + COORD_W'(1);
          end else begin
            cx <= cx + COORD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      lcd_cs         <= 1'b1;
      mem_chipselect <= 1'b0;
      mem_clken      <= 1'b0;
      mem_address    <= '0;
    end else begin
      busy           <= busy_d;
      done           <= done_d;
      err            <= err_d;
      lcd_cs         <= cs_d;
      mem_chipselect <= mcs_d;
      mem_clken      <= mcs_d;
      mem_address    <= addr_d;
    end
  end

  assign lcd_rd = 1'b1;

  lt24_bus_word #(
    .WR_LOW_CYC  (WR_LOW_CYC),
    .WR_HIGH_CYC (WR_HIGH_CYC)
  ) u_bus_word (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (go_c),
    .rs        (bw_c.rs),
    .data      (bw_c.data),
    .word_done (word_done),
    .lcd_wr    (lcd_wr),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data)
  );

endmodule

// File: tb/tb_lt24_frame_writer.sv
// Directed + randomized bench for lt24_frame_writer with a layer-memory model,
// an 8080 bus monitor and a reference compositor.
module tb_lt24_frame_writer;

  localparam int NL      = 3;
  localparam int AW      = 13;
  localparam int WL      = 2;
  localparam int WH      = 1;
  localparam int DEPTH   = 1 << AW;
  localparam int PIX_PER = 2 + WL + WH;
  localparam logic [15:0] KEY = 16'hF81F;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [8:0]      x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic [NL-1:0]   layer_en = '0;
  logic            busy, done, err;
  logic [NL*AW-1:0] mem_address;
  logic            mem_chipselect, mem_clken;
  logic [NL*16-1:0] mem_readdata;
  logic            lcd_cs, lcd_rs, lcd_rd, lcd_wr;
  logic [15:0]     lcd_data;

  logic [15:0] mem [NL][DEPTH];
  logic [15:0] rd  [NL];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lt24_frame_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .x0             (x0),
    .x1             (x1),
    .y0             (y0),
    .y1             (y1),
    .layer_en       (layer_en),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .lcd_cs         (lcd_cs),
    .lcd_rs         (lcd_rs),
    .lcd_rd         (lcd_rd),
    .lcd_wr         (lcd_wr),
    .lcd_data       (lcd_data)
  );

  // Synchronous memories with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken)
      for (int l = 0; l < NL; l++) rd[l] <= mem[l][mem_address[l*AW +: AW]];
  end
  assign mem_readdata = {rd[2], rd[1], rd[0]};

  // Bus monitor state
  logic [16:0] wq[$];
  int          tq[$];
  int          aq[$];
  int done_cnt, err_cnt, busy_cnt, cs_low_cnt, cyc;
  int viol_len, viol_high, viol_chg, viol_cs, viol_rd, viol_mem;
  logic        prev_wr;
  logic [15:0] prev_data;
  int          low_len, high_len, fall_cyc;
  logic [16:0] cur;
  bit          seen_word;

  initial begin
    done_cnt = 0; err_cnt = 0; busy_cnt = 0; cs_low_cnt = 0; cyc = 0;
    viol_len = 0; viol_high = 0; viol_chg = 0; viol_cs = 0; viol_rd = 0; viol_mem = 0;
    prev_wr = 1'b1; prev_data = '0; low_len = 0; high_len = 0; fall_cyc = 0;
    cur = '0; seen_word = 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      prev_wr = 1'b1; prev_data = lcd_data; low_len = 0; high_len = 0; seen_word = 0;
    end else begin
      if (lcd_rd !== 1'b1) viol_rd++;
      if (lcd_wr === 1'b0 && lcd_cs !== 1'b0) viol_cs++;
      if (prev_wr === 1'b0 && lcd_data !== prev_data) viol_chg++;
      if (lcd_wr === 1'b0) begin
        if (prev_wr === 1'b1) begin
          if (seen_word && high_len < WH) viol_high++;
          low_len = 0; fall_cyc = cyc;
        end
        low_len++;
        cur = {lcd_rs, lcd_data};
      end else begin
        if (prev_wr === 1'b0) begin
          if (low_len != WL) viol_len++;
          wq.push_back(cur); tq.push_back(fall_cyc);
          seen_word = 1; high_len = 0;
        end
        high_len++;
      end
      if (mem_chipselect === 1'b1) begin
        if (mem_clken !== 1'b1) viol_mem++;
        for (int l = 1; l < NL; l++)
          if (mem_address[l*AW +: AW] !== mem_address[AW-1:0]) viol_mem++;
        aq.push_back(int'(mem_address[AW-1:0]));
      end else if (mem_clken === 1'b1) viol_mem++;
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (lcd_cs === 1'b0) cs_low_cnt++;
      prev_wr = lcd_wr;
      prev_data = lcd_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete(); tq.delete(); aq.delete();
    done_cnt = 0; err_cnt = 0; busy_cnt = 0; cs_low_cnt = 0;
  endtask

  task automatic pulse_start(input int ax0, ax1, ay0, ay1, input logic [NL-1:0] en);
    x0 = 9'(ax0); x1 = 9'(ax1); y0 = 9'(ay0); y1 = 9'(ay1);
    layer_en = en; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin @(posedge clk); #1; c++; end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'(1));
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Expected window-setup word k: command codes with rs=0, byte parameters with rs=1.
  function automatic logic [16:0] exp_cmd(input int k, input int ax0, ax1, ay0, ay1);
    int v [11];
    v = '{'h2A, ax0 / 256, ax0 % 256, ax1 / 256, ax1 % 256,
          'h2B, ay0 / 256, ay0 % 256, ay1 / 256, ay1 % 256, 'h2C};
    return {(k == 0 || k == 5 || k == 10) ? 1'b0 : 1'b1, 16'(v[k])};
  endfunction

  // Reference compositor for pixel index idx.
  function automatic logic [15:0] model_px(input int idx, input logic [NL-1:0] en);
    int a = idx % DEPTH;
`ifdef LT24_FRAME_WRITER_TRANSPARENCY_EN
    for (int l = NL - 1; l >= 0; l--)
      if (en[l] && mem[l][a] != KEY) return mem[l][a];
    for (int l = 0; l < NL; l++)
      if (en[l]) return mem[l][a];
    return 16'h0000;
`else
    for (int l = NL - 1; l >= 0; l--)
      if (en[l]) return mem[l][a];
    return 16'h0000;
`endif
  endfunction

  task automatic run_window(input string tag, input int ax0, ax1, ay0, ay1,
                            input logic [NL-1:0] en);
    int n;
    n = (ax1 - ax0 + 1) * (ay1 - ay0 + 1);
    clear_mon();
    pulse_start(ax0, ax1, ay0, ay1, en);
    wait_done(tag, 11 * (WL + WH) + n * PIX_PER + 40);
    check({tag, "_nwords"}, 32'(wq.size()), 32'(11 + n));
    if (wq.size() == 11 + n) begin
      for (int k = 0; k < 11; k++)
        check($sformatf("%s_cmd%0d", tag, k), 32'(wq[k]), 32'(exp_cmd(k, ax0, ax1, ay0, ay1)));
      for (int i = 0; i < n; i++)
        check($sformatf("%s_pix%0d", tag, i), 32'(wq[11+i]), 32'({1'b1, model_px(i, en)}));
      for (int i = 1; i < n; i++)
        check($sformatf("%s_period%0d", tag, i), 32'(tq[11+i] - tq[10+i]), 32'(PIX_PER));
    end
    check({tag, "_naddr"}, 32'(aq.size()), 32'(n));
    if (aq.size() == n)
      for (int i = 0; i < n; i++)
        check($sformatf("%s_addr%0d", tag, i), 32'(aq[i]), 32'(i % DEPTH));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
    check({tag, "_busy_end"}, 32'(busy), 32'(0));
    check({tag, "_cs_end"}, 32'(lcd_cs), 32'(1));
  endtask

  initial begin
    int c;
    int bad_win [4][4];
    logic [15:0] exp_t;

    for (int l = 0; l < NL; l++)
      for (int i = 0; i < DEPTH; i++)
        mem[l][i] = ($urandom_range(0, 3) == 0) ? KEY : 16'($urandom);
    for (int l = 0; l < NL; l++) rd[l] = '0;

    // Reset values
    repeat (3) begin @(posedge clk); #1; end
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_cs", 32'(lcd_cs), 32'(1));
    check("rst_wr", 32'(lcd_wr), 32'(1));
    check("rst_rd", 32'(lcd_rd), 32'(1));
    check("rst_rs", 32'(lcd_rs), 32'(1));
    check("rst_data", 32'(lcd_data), 32'(0));
    check("rst_addr", 32'(mem_address), 32'(0));
    check("rst_memcs", 32'({mem_chipselect, mem_clken}), 32'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic two-pixel window from layer 0
    run_window("basic", 0, 1, 0, 0, 3'b001);

    // Invalid windows
    bad_win = '{'{0, 320, 0, 0}, '{5, 4, 0, 0}, '{0, 0, 0, 240}, '{0, 0, 3, 2}};
    for (int b = 0; b < 4; b++) begin
      clear_mon();
      pulse_start(bad_win[b][0], bad_win[b][1], bad_win[b][2], bad_win[b][3], 3'b001);
      repeat (5) begin @(posedge clk); #1; end
      check($sformatf("err%0d_pulse", b), 32'(err_cnt), 32'(1));
      check($sformatf("err%0d_busy", b), 32'(busy_cnt), 32'(0));
      check($sformatf("err%0d_cs", b), 32'(cs_low_cnt), 32'(0));
      check($sformatf("err%0d_words", b), 32'(wq.size()), 32'(0));
    end

    // Transparency key on the top layer
    mem[0][0] = 16'h1234;
    mem[1][0] = 16'h07E0;
    mem[2][0] = KEY;
`ifdef LT24_FRAME_WRITER_TRANSPARENCY_EN
    exp_t = 16'h07E0;
`else
    exp_t = 16'hF81F;
`endif
    run_window("transp", 0, 0, 0, 0, 3'b111);
    if (wq.size() == 12) check("transp_const", 32'(wq[11]), 32'({1'b1, exp_t}));

    // All layers disabled
    run_window("noen", 0, 0, 0, 0, 3'b000);
    if (wq.size() == 12) check("noen_const", 32'(wq[11]), 32'({1'b1, 16'h0000}));

    // Single pixel at (5,7)
    run_window("single", 5, 5, 7, 7, 3'b101);

    // Randomized windows, some near the right/bottom edges
    for (int r = 0; r < 8; r++) begin
      int w, h, ax, ay;
      w  = $urandom_range(0, 5);
      h  = $urandom_range(0, 3);
      ax = (r % 2 == 0) ? $urandom_range(0, 319 - w) : 319 - w;
      ay = (r % 3 == 0) ? 239 - h : $urandom_range(0, 239 - h);
      run_window($sformatf("rnd%0d", r), ax, ax + w, ay, ay + h, NL'($urandom_range(0, 7)));
    end

    // Second start during CMD is ignored
    clear_mon();
    pulse_start(0, 2, 0, 0, 3'b010);
    repeat (4) begin @(posedge clk); #1; end
    pulse_start(10, 20, 3, 9, 3'b111);
    wait_done("dblstart", 11 * (WL + WH) + 3 * PIX_PER + 40);
    repeat (80) begin @(posedge clk); #1; end
    check("dbl_done_cnt", 32'(done_cnt), 32'(1));
    check("dbl_nwords", 32'(wq.size()), 32'(14));
    if (wq.size() == 14) begin
      check("dbl_x1lo", 32'(wq[4]), 32'(exp_cmd(4, 0, 2, 0, 0)));
      check("dbl_pix2", 32'(wq[13]), 32'({1'b1, model_px(2, 3'b010)}));
    end

    // Reset asserted while a pixel word is on the bus
    clear_mon();
    pulse_start(0, 3, 0, 1, 3'b011);
    c = 0;
    while ((wq.size() < 12 || lcd_wr !== 1'b0) && c < 400) begin @(posedge clk); #1; c++; end
    check("midrst_reached", 32'(wq.size() >= 12 && lcd_wr === 1'b0), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check("midrst_cs", 32'(lcd_cs), 32'(1));
    check("midrst_wr", 32'(lcd_wr), 32'(1));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_memcs", 32'(mem_chipselect), 32'(0));
    check("midrst_data", 32'(lcd_data), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_window("postrst", 2, 4, 1, 2, 3'b110);

    // Bus protocol observations accumulated across the run
    check("viol_wr_low_len", 32'(viol_len), 32'(0));
    check("viol_wr_high_len", 32'(viol_high), 32'(0));
    check("viol_data_change", 32'(viol_chg), 32'(0));
    check("viol_cs_during_wr", 32'(viol_cs), 32'(0));
    check("viol_rd", 32'(viol_rd), 32'(0));
    check("viol_mem_strobes", 32'(viol_mem), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
